cpu_multicycle: RTL and testbench



---
 rtl/cpu_multicycle.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset CPU. It executes one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB. Instruction and data accesses share one memory
// port that uses a req/ack handshake, so the memory may insert any number of
// wait states.
//
// Handshake: mem_req/mem_we/mem_addr/mem_wdata are decoded from registered
// state only and hold steady until the edge where mem_ack is sampled high.
// Each ack completes exactly one request. An ack while mem_req is low is
// ignored. While rst is high, mem_req and mem_we are forced low and any ack
// has no effect.
module cpu_multicycle #(
    parameter int          REG_N    = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted
);

    localparam int IDX_W = $clog2(REG_N);
    // Register-index bits above the implemented range. An index with any of
    // these bits set reads as zero, and a write to it is dropped.
    localparam logic [4:0] HI_MASK = 5'(~((32'd1 << IDX_W) - 32'd1));

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } cls_t;

    state_t             state_q, state_d;
    cls_t               cls;
    logic [ADDR_W-1:0]  pc_q;
    logic [31:0]        ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0]        regs [REG_N];

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] sext_imm, br_off32, pc_ext, j_target;
    logic [31:0] rs_val, rt_val, alu_res, wr_data;
    logic [4:0]  wr_idx;
    logic        wr_en;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign imm26    = ir_q[25:0];
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign br_off32 = {{14{imm16[15]}}, imm16, 2'b00};
    assign pc_ext   = 32'(pc_q);
    assign j_target = (pc_ext & 32'hF000_0000) | {4'b0000, imm26, 2'b00};

    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = (state_q == S_HALT);
    assign mem_wdata = b_q;

    function automatic logic idx_ok(input logic [4:0] idx);
        return ((idx & HI_MASK) == 5'd0) && (idx != 5'd0);
    endfunction

    // Classify the held instruction. halt and every unsupported encoding map to C_ILL.
    always_comb begin
        cls = C_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: cls = C_RTYPE;
                    default:                           cls = C_ILL;
                endcase
            end
            6'h08:   cls = C_ADDI;
            6'h23:   cls = C_LW;
            6'h2B:   cls = C_SW;
            6'h04:   cls = C_BEQ;
            6'h02:   cls = C_J;
            default: cls = C_ILL;
        endcase
    end

    // Register-file read ports. Register 0 and out-of-range indices read as zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (idx_ok(rs)) rs_val = regs[rs[IDX_W-1:0]];
        if (idx_ok(rt)) rt_val = regs[rt[IDX_W-1:0]];
    end

    // ALU for the R-type functions and addi. Arithmetic wraps, with no overflow trap.
    always_comb begin
        alu_res = a_q + sext_imm;
        if (cls == C_RTYPE) begin
            case (funct)
                6'h20:   alu_res = a_q + b_q;
                6'h22:   alu_res = a_q - b_q;
                6'h24:   alu_res = a_q & b_q;
                6'h25:   alu_res = a_q | b_q;
                6'h2A:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    // Write-back target selection: rd for R-type, rt for addi and lw.
    always_comb begin
        wr_idx  = (cls == C_RTYPE) ? rd : rt;
        wr_data = (cls == C_LW) ? mdr_q : alu_q;
        wr_en   = idx_ok(wr_idx);
    end

    // FSM next state and memory-port outputs, all decoded from registered state.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:      state_d = S_MEM;
                    C_BEQ, C_J:      state_d = S_FETCH;
                    default:         state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (cls == C_SW);
                mem_addr = alu_q[ADDR_W-1:0];
                if (mem_ack) state_d = (cls == C_SW) ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Datapath registers and register file, updated per the current FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC[ADDR_W-1:0];
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= rt_val;
                end
                S_EXEC: begin
                    case (cls)
                        C_RTYPE, C_ADDI: alu_q <= alu_res;
                        C_LW, C_SW:      alu_q <= a_q + sext_imm;
                        C_BEQ: if (a_q == b_q) pc_q <= pc_q + br_off32[ADDR_W-1:0];
                        C_J:             pc_q <= j_target[ADDR_W-1:0];
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack && cls == C_LW) mdr_q <= mem_rdata;
                end
                S_WB: begin
                    if (wr_en) regs[wr_idx[IDX_W-1:0]] <= wr_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle (REG_N=8, RESET_PC=0x100). A behavioural memory
// with a programmable wait count answers the req/ack port. The main process
// loads programs and pushes the expected bus transactions. A monitor checks
// every requesting cycle against the head of the queue, and checks the cycle
// gap between acks.
module tb_cpu_multicycle;

    localparam int ADDR_W = 32;
    localparam int EXP_W  = 73;  // {gap[7:0], we, addr[31:0], wdata[31:0]}

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req, mem_we, mem_ack, halted;
    logic [ADDR_W-1:0] mem_addr, pc;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic [2:0]        state;
    logic              ack_r = 1'b0;
    logic              force_ack = 1'b0;

    logic [31:0]       mem [0:255];
    int                wait_n = 0;
    int                cnt = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                last_ack = 0;
    logic [EXP_W-1:0]  exp_q[$];

    assign mem_ack = ack_r | force_ack;

    cpu_multicycle #(.REG_N(8), .ADDR_W(ADDR_W), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .state(state), .halted(halted)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] insn);
        mem[a[9:2]] = insn;
    endtask

    task automatic ef(input logic [31:0] a, input int g);
        exp_q.push_back({8'(g), 1'b0, a, 32'h0});
    endtask

    task automatic es(input logic [31:0] a, input logic [31:0] d, input int g);
        exp_q.push_back({8'(g), 1'b1, a, d});
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d transactions outstanding after %0d cycles", exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    // Memory model: ack after wait_n stall cycles; writes land at the ack decision
    initial begin
        forever begin
            @(posedge clk); #2;
            if (mem_req) begin
                if (cnt >= wait_n) begin
                    ack_r     = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    cnt = 0;
                end else begin
                    ack_r = 1'b0;
                    cnt++;
                end
            end else begin
                ack_r = 1'b0;
                cnt   = 0;
            end
        end
    end

    // Monitor: compare each requesting cycle with the queue head and pop on ack
    initial begin
        logic [7:0]  g;
        logic        w;
        logic [31:0] a, d;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && mem_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h we %b, required no request", mem_addr, mem_we);
                end else begin
                    {g, w, a, d} = exp_q[0];
                    chk("req_we", 32'(mem_we), 32'(w));
                    chk("req_addr", mem_addr, a);
                    if (w) chk("req_wdata", mem_wdata, d);
                    if (mem_ack) begin
                        if (g != 8'd0) chk("ack_gap", 32'(cyc - last_ack), 32'(g));
                        last_ack = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Stimulus and directed checks
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        put(32'h100, 32'h20010005);  // addi r1,r0,5
        put(32'h104, 32'h2002FFFD);  // addi r2,r0,-3
        put(32'h108, 32'h00221820);  // add  r3,r1,r2   -> 2
        put(32'h10C, 32'h0041202A);  // slt  r4,r2,r1   -> 1
        put(32'h110, 32'h00222822);  // sub  r5,r1,r2   -> 8
        put(32'h114, 32'h00233025);  // or   r6,r1,r3   -> 7
        put(32'h118, 32'h00413824);  // and  r7,r2,r1   -> 5
        put(32'h11C, 32'hAC030200);  // sw r3,0x200
        put(32'h120, 32'hAC040204);  // sw r4,0x204
        put(32'h124, 32'hAC050208);  // sw r5,0x208
        put(32'h128, 32'hAC06020C);  // sw r6,0x20C
        put(32'h12C, 32'hAC070210);  // sw r7,0x210
        put(32'h130, 32'h0022202A);  // slt r4,r1,r2    -> 0
        put(32'h134, 32'hAC040214);  // sw r4,0x214
        put(32'h138, 32'h20090007);  // addi r9,r0,7 (out of range, dropped)
        put(32'h13C, 32'h20000001);  // addi r0,r0,1 (discarded)
        put(32'h140, 32'hAC090218);  // sw r9,0x218     -> 0
        put(32'h144, 32'hAC00021C);  // sw r0,0x21C     -> 0
        put(32'h148, 32'h10220005);  // beq r1,r2,+5 (not taken)
        put(32'h14C, 32'h10210001);  // beq r1,r1,+1 -> 0x154
        put(32'h150, 32'hFC000000);  // halt (skipped)
        put(32'h154, 32'h08000058);  // j 0x160
        put(32'h160, 32'h1021FFFF);  // beq r1,r1,-1 (self loop)
        put(32'h180, 32'hAC010008);  // sw r1,8
        put(32'h184, 32'h8C050008);  // lw r5,8
        put(32'h188, 32'hAC050224);  // sw r5,0x224
        put(32'h18C, 32'hF8000000);  // illegal op 0x3E

        // Reset state
        wait_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_halted", 32'(halted), 32'd0);

        // Zero-wait program: ALU ops, stores, dropped writes, branches
        ef(32'h100, 0); ef(32'h104, 4); ef(32'h108, 4); ef(32'h10C, 4);
        ef(32'h110, 4); ef(32'h114, 4); ef(32'h118, 4); ef(32'h11C, 4);
        es(32'h200, 32'h2, 3); ef(32'h120, 1);
        es(32'h204, 32'h1, 3); ef(32'h124, 1);
        es(32'h208, 32'h8, 3); ef(32'h128, 1);
        es(32'h20C, 32'h7, 3); ef(32'h12C, 1);
        es(32'h210, 32'h5, 3); ef(32'h130, 1);
        ef(32'h134, 4); es(32'h214, 32'h0, 3);
        ef(32'h138, 1); ef(32'h13C, 4); ef(32'h140, 4);
        es(32'h218, 32'h0, 3); ef(32'h144, 1);
        es(32'h21C, 32'h0, 3); ef(32'h148, 1);
        ef(32'h14C, 3); ef(32'h154, 3); ef(32'h160, 3);
        ef(32'h160, 3); ef(32'h160, 3);
        rst = 1'b0;
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        chk("first_state", 32'(state), 32'd0);
        drain(400);

        // Break the self loop and switch to 3-wait memory for the store/load part
        put(32'h160, 32'h08000060);  // j 0x180
        wait_n = 3;
        ef(32'h160, 6); ef(32'h180, 6);
        es(32'h8, 32'h5, 6); ef(32'h184, 4);
        ef(32'h8, 6); ef(32'h188, 5);
        es(32'h224, 32'h5, 6); ef(32'h18C, 4);
        drain(400);
        chk("ill_decode_state", 32'(state), 32'd1);
        @(posedge clk); #1;
        chk("ill_exec_state", 32'(state), 32'd2);
        chk("ill_exec_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;
        chk("ill_halt_state", 32'(state), 32'd5);
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_pc", pc, 32'h190);

        // Acks with no request outstanding are ignored while halted
        force_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("stray_ack_state", 32'(state), 32'd5);
        chk("stray_ack_pc", pc, 32'h190);

        // Reset pulse while a fetch is pending, with an ack in the reset cycle
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_halted", 32'(halted), 32'd0);
        ef(32'h100, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("pend_req", 32'(mem_req), 32'd1);
        chk("pend_addr", mem_addr, 32'h100);
        rst = 1'b1;
        force_ack = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pc", pc, 32'h100);
        chk("abort_mem_req", 32'(mem_req), 32'd0);

        // Restart onto a halt instruction: HALT is reached in 3 cycles
        put(32'h100, 32'hFC000000);
        wait_n = 0;
        force_ack = 1'b0;
        ef(32'h100, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("halt_decode_state", 32'(state), 32'd1);
        @(posedge clk); #1;
        chk("halt_exec_state", 32'(state), 32'd2);
        chk("halt_exec_halted", 32'(halted), 32'd0);
        @(posedge clk); #1;
        chk("halt_state", 32'(state), 32'd5);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", pc, 32'h104);
        drain(2);
        repeat (3) @(posedge clk);
        #1;
        chk("halt_absorb", 32'(state), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
